// File: rtl/btn_debounce_pkg.sv
// Shared types for the multi-channel button debouncer: per-channel FSM state
// encoding and a parameter sanity check used at elaboration.
package btn_debounce_pkg;

  localparam logic [1:0] ENC_IDLE         = 2'b00;
  localparam logic [1:0] ENC_PRESS_WAIT   = 2'b01;
  localparam logic [1:0] ENC_HELD         = 2'b11;
  localparam logic [1:0] ENC_RELEASE_WAIT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE         = ENC_IDLE,
    ST_PRESS_WAIT   = ENC_PRESS_WAIT,
    ST_HELD         = ENC_HELD,
    ST_RELEASE_WAIT = ENC_RELEASE_WAIT
  } db_state_t;

  function automatic bit cfg_ok(input int num_ch, input int stable,
                                input int rdelay, input int rperiod);
    return (num_ch >= 1) && (num_ch <= 32) && (stable >= 2) &&
           (stable <= 65535) && (rdelay >= 1) && (rperiod >= 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability FSM and pulse outputs.
// Auto-repeat on hold is built in when BTN_DEBOUNCE_REPEAT_EN is defined.
//
// state         | meaning
// IDLE          | debounced level 0, input agrees
// PRESS_WAIT    | input went high, counting stable high samples
// HELD          | debounced level 1, input agrees
// RELEASE_WAIT  | input went low, counting stable low samples
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 11
`ifdef BTN_DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
`endif
) (
  input  logic debounce_clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          sync_q1, sync_in;
  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_d, press_d, release_d;

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (sync_in) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CW'(1);
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_in) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        if (!sync_in) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = CW'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync_in) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef BTN_DEBOUNCE_REPEAT_EN
    // Down-counter reloads on fresh acceptance, pauses while release is pending.
    rpt_d = rpt_q;
    if (state_q == ST_PRESS_WAIT && state_d == ST_HELD) begin
      rpt_d = RPT_W'(REPEAT_DELAY);
    end else if (state_q == ST_HELD && state_d == ST_HELD) begin
      if (rpt_q == RPT_W'(1)) begin
        rpt_d   = RPT_W'(REPEAT_PERIOD);
        press_d = 1'b1;
      end else begin
        rpt_d = rpt_q - RPT_W'(1);
      end
    end
`endif

    level_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
  end

  always_ff @(posedge debounce_clk) begin
    if (rst) begin
      sync_q1       <= 1'b0;
      sync_in       <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q1       <= btn;
      sync_in       <= sync_q1;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      level         <= level_d;
      press         <= press_d;
      release_pulse <= release_d;
    end
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  always_ff @(posedge debounce_clk) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end
`endif

endmodule

// File: rtl/btn_debounce_n.sv
// NUM_CH independent debounced buttons with press/release pulses.
// Define BTN_DEBOUNCE_REPEAT_EN to auto-repeat press while a button is held.
module btn_debounce_n
  import btn_debounce_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int STABLE_CYCLES = 11,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic              debounce_clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press,
  // "release" is a reserved word, hence the suffix
  output logic [NUM_CH-1:0] release_pulse
);

  if (!cfg_ok(NUM_CH, STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) begin : g_cfg_bad
    $error("btn_debounce_n: parameter out of range");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES)
`ifdef BTN_DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_ch (
      .debounce_clk (debounce_clk),
      .rst          (rst),
      .btn          (btn[g]),
      .level        (level[g]),
      .press        (press[g]),
      .release_pulse(release_pulse[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce_n.sv
// Bench for btn_debounce_n: directed scenarios plus random stimulus, all
// checked every cycle against a run-length reference model.
module tb_btn_debounce_n;

  localparam int NUM_CH  = 4;
  localparam int STABLE  = 4;
  localparam int RDELAY  = 8;
  localparam int RPERIOD = 3;

  logic              debounce_clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] btn;
  logic [NUM_CH-1:0] level, press, release_pulse;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: synchroniser pipeline, accepted level, run length of
  // samples disagreeing with it, and count of settled-hold cycles.
  logic [NUM_CH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_press = '0, m_rel = '0;
  int m_run [NUM_CH];
  int m_held[NUM_CH];

  always #5 debounce_clk = ~debounce_clk;

  btn_debounce_n #(
    .NUM_CH(NUM_CH), .STABLE_CYCLES(STABLE),
    .REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPERIOD)
  ) dut (
    .debounce_clk (debounce_clk),
    .rst          (rst),
    .btn          (btn),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_run[c]  = 0;
        m_held[c] = 0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_press[c] = 1'b0;
        m_rel[c]   = 1'b0;
        if (m_s2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == STABLE) begin
            m_lvl[c]  = m_s2[c];
            m_run[c]  = 0;
            m_held[c] = 0;
            if (m_s2[c]) m_press[c] = 1'b1;
            else         m_rel[c]   = 1'b1;
          end
        end else begin
          if (m_lvl[c] && m_run[c] == 0) begin
            m_held[c]++;
`ifdef BTN_DEBOUNCE_REPEAT_EN
            if (m_held[c] >= RDELAY && (m_held[c] - RDELAY) % RPERIOD == 0)
              m_press[c] = 1'b1;
`endif
          end
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  endtask

  task automatic tick(input string tag);
    @(posedge debounce_clk);
    model_edge();
    #1;
    chk({tag, " level"},   32'(level),         32'(m_lvl));
    chk({tag, " press"},   32'(press),         32'(m_press));
    chk({tag, " release"}, 32'(release_pulse), 32'(m_rel));
    chk({tag, " excl"},    32'(press & release_pulse), 32'd0);
  endtask

  initial begin
    int rel_cnt, press_cnt;
    logic bounce_seen;
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c]  = 0;
      m_held[c] = 0;
    end

    // reset
    rst = 1'b1;
    btn = '0;
    for (int i = 0; i < 3; i++) tick("reset");
    chk("reset level_zero", 32'(level), 32'd0);
    rst = 1'b0;

    // single press latency on ch0
    btn = 4'b0001;
    for (int i = 0; i < 5; i++) tick("p033");
    chk("p033 level_early", 32'(level), 32'd0);
    tick("p033");
    chk("p033 level_set", 32'(level), 32'b0001);
    chk("p033 press_set", 32'(press), 32'b0001);
    chk("p033 release_zero", 32'(release_pulse), 32'd0);
    tick("p033");
    chk("p033 press_once", 32'(press), 32'd0);

    // glitch during release wait, then clean release
    btn[0] = 1'b0;
    rel_cnt = 0; press_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      tick("g035");
      chk("g035 hold_level", 32'(level[0]), 32'd1);
    end
    btn[0] = 1'b1;
    tick("g035");
    chk("g035 hold_level", 32'(level[0]), 32'd1);
    btn[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick("g035");
      if (i < 2) chk("g035 hold_level", 32'(level[0]), 32'd1);
      rel_cnt   += int'(release_pulse[0]);
      press_cnt += int'(press[0]);
    end
    chk("g035 release_count", 32'(rel_cnt), 32'd1);
    chk("g035 press_count", 32'(press_cnt), 32'd0);
    chk("g035 level_final", 32'(level[0]), 32'd0);

    // bounce on ch1 never accepted
    bounce_seen = 1'b0;
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 3; k++) begin
        btn[1] = (k != 2);
        tick("b034");
        bounce_seen |= level[1] | press[1] | release_pulse[1];
      end
    end
    btn[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick("b034");
      bounce_seen |= level[1] | press[1] | release_pulse[1];
    end
    chk("b034 no_activity", 32'(bounce_seen), 32'd0);

    // simultaneous press and release on ch0 and ch3
    btn = 4'b1001;
    for (int i = 0; i < 5; i++) tick("s036");
    chk("s036 press_early", 32'(press), 32'd0);
    tick("s036");
    chk("s036 press_both", 32'(press), 32'b1001);
    chk("s036 level_both", 32'(level), 32'b1001);
    tick("s036");
    btn = 4'b0000;
    for (int i = 0; i < 5; i++) tick("s036");
    chk("s036 release_early", 32'(release_pulse), 32'd0);
    tick("s036");
    chk("s036 release_both", 32'(release_pulse), 32'b1001);
    chk("s036 level_clear", 32'(level), 32'd0);
    tick("s036");

    // reset while ch2 held, then re-acceptance
    btn = 4'b0100;
    for (int i = 0; i < 6; i++) tick("r037");
    chk("r037 press_ch2", 32'(press), 32'b0100);
    tick("r037");
    tick("r037");
    rst = 1'b1;
    tick("r037");
    chk("r037 level_drop", 32'(level), 32'd0);
    chk("r037 no_release", 32'(release_pulse), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick("r037");
    chk("r037 press_not_yet", 32'(press), 32'd0);
    tick("r037");
    chk("r037 press_again", 32'(press), 32'b0100);
    chk("r037 level_again", 32'(level), 32'b0100);

    // random stimulus, sticky bits so presses actually settle
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 5) == 0) btn[c] = ~btn[c];
      rst = ($urandom_range(0, 149) == 0);
      tick("rand");
    end
    rst = 1'b0;
    btn = '0;
    for (int i = 0; i < 10; i++) tick("drain");

`ifdef BTN_DEBOUNCE_REPEAT_EN
    begin
      int hits[$];
      rst = 1'b1;
      tick("p038");
      rst = 1'b0;
      btn = 4'b0001;
      for (int i = 0; i < 30; i++) begin
        tick("p038");
        if (press[0]) hits.push_back(i);
      end
      chk("p038 pulse_count", 32'(hits.size()), 32'd7);
      if (hits.size() >= 4) begin
        chk("p038 first_at", 32'(hits[0]), 32'd5);
        chk("p038 delay_gap", 32'(hits[1] - hits[0]), 32'(RDELAY));
        chk("p038 period_gap1", 32'(hits[2] - hits[1]), 32'(RPERIOD));
        chk("p038 period_gap2", 32'(hits[3] - hits[2]), 32'(RPERIOD));
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
